// File: rtl/idvr_addsub_arb.sv
// Round-robin arbiter sharing one add/sub/compare datapath across N requesters.
// Optional macro IDVR_ADDSUB_ARB_ERR_EN: flag illegal op codes on RSP_ERR.
module idvr_addsub #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [3:0]   op_i,
    output logic [W-1:0] y_o
);
    always_comb begin
        y_o = a_i + b_i;
        case (op_i)
            4'b1000: y_o = a_i - b_i;
            4'b0010: y_o = {{(W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            4'b0011: y_o = {{(W-1){1'b0}}, a_i < b_i};
            default: y_o = a_i + b_i;
        endcase
    end
endmodule

module idvr_addsub_arb #(
    parameter int W  = 32,
    parameter int N  = 4,
    parameter int IW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [N-1:0]  REQ_V,
    output logic [N-1:0]  REQ_R,
    input  logic [N*W-1:0] REQ_I0,
    input  logic [N*W-1:0] REQ_I1,
    input  logic [N*4-1:0] REQ_S,
    output logic          RSP_V,
    input  logic          RSP_R,
    output logic [W-1:0]  RSP_O,
`ifdef IDVR_ADDSUB_ARB_ERR_EN
    output logic          RSP_ERR,
`endif
    output logic [IW-1:0] RSP_ID
);
    logic          rsp_v_q, rsp_v_d;
    logic [W-1:0]  rsp_o_q, rsp_o_d;
    logic [IW-1:0] rsp_id_q, rsp_id_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic          acc, gnt_any, xfer;
    logic [IW-1:0] gnt_idx;
    logic [IW:0]   cand;
    logic [W-1:0]  sel_a, sel_b, dp_y;
    logic [3:0]    sel_op;

    // Scan PTR, PTR+1, ... wrapping at N; first valid wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
            if (!gnt_any && REQ_V[cand[IW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[IW-1:0];
            end
        end
    end

    assign acc   = ~rsp_v_q | RSP_R;
    assign xfer  = gnt_any & acc;
    assign REQ_R = xfer ? (N'(1) << gnt_idx) : '0;

    assign sel_a  = REQ_I0[gnt_idx*W +: W];
    assign sel_b  = REQ_I1[gnt_idx*W +: W];
    assign sel_op = REQ_S[gnt_idx*4 +: 4];

    idvr_addsub #(.W(W)) u_dp (
        .a_i (sel_a),
        .b_i (sel_b),
        .op_i(sel_op),
        .y_o (dp_y)
    );

`ifdef IDVR_ADDSUB_ARB_ERR_EN
    logic rsp_err_q, rsp_err_d, legal;
    assign legal = (sel_op == 4'b0000) | (sel_op == 4'b1000) |
                   (sel_op == 4'b0010) | (sel_op == 4'b0011);
`endif

    always_comb begin
        rsp_v_d  = rsp_v_q;
        rsp_o_d  = rsp_o_q;
        rsp_id_d = rsp_id_q;
        ptr_d    = ptr_q;
`ifdef IDVR_ADDSUB_ARB_ERR_EN
        rsp_err_d = rsp_err_q;
`endif
        if (xfer) begin
            rsp_v_d  = 1'b1;
            rsp_id_d = gnt_idx;
            ptr_d    = (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
`ifdef IDVR_ADDSUB_ARB_ERR_EN
            rsp_o_d   = legal ? dp_y : '0;
            rsp_err_d = ~legal;
`else
            rsp_o_d  = dp_y;
`endif
        end else if (rsp_v_q && RSP_R) begin
            rsp_v_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_v_q  <= 1'b0;
            rsp_o_q  <= '0;
            rsp_id_q <= '0;
            ptr_q    <= '0;
`ifdef IDVR_ADDSUB_ARB_ERR_EN
            rsp_err_q <= 1'b0;
`endif
        end else begin
            rsp_v_q  <= rsp_v_d;
            rsp_o_q  <= rsp_o_d;
            rsp_id_q <= rsp_id_d;
            ptr_q    <= ptr_d;
`ifdef IDVR_ADDSUB_ARB_ERR_EN
            rsp_err_q <= rsp_err_d;
`endif
        end
    end

    assign RSP_V  = rsp_v_q;
    assign RSP_O  = rsp_o_q;
    assign RSP_ID = rsp_id_q;
`ifdef IDVR_ADDSUB_ARB_ERR_EN
    assign RSP_ERR = rsp_err_q;
`endif
endmodule

// File: tb/tb_idvr_addsub_arb.sv
// Directed bench for idvr_addsub_arb at W=8, N=4.
// Define IDVR_ADDSUB_ARB_ERR_EN to also exercise the illegal-op flag.
module tb_idvr_addsub_arb;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int IW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_v;
    logic [N-1:0]   req_r;
    logic [N*W-1:0] req_i0;
    logic [N*W-1:0] req_i1;
    logic [N*4-1:0] req_s;
    logic           rsp_v;
    logic           rsp_r;
    logic [W-1:0]   rsp_o;
    logic [IW-1:0]  rsp_id;
`ifdef IDVR_ADDSUB_ARB_ERR_EN
    logic           rsp_err;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    idvr_addsub_arb #(.W(W), .N(N), .IW(IW)) dut (
        .CLK    (clk),
        .RST    (rst),
        .REQ_V  (req_v),
        .REQ_R  (req_r),
        .REQ_I0 (req_i0),
        .REQ_I1 (req_i1),
        .REQ_S  (req_s),
        .RSP_V  (rsp_v),
        .RSP_R  (rsp_r),
        .RSP_O  (rsp_o),
`ifdef IDVR_ADDSUB_ARB_ERR_EN
        .RSP_ERR(rsp_err),
`endif
        .RSP_ID (rsp_id)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input int v, input int o,
                           input int id);
        chk({tag, ".v"}, int'(rsp_v), v);
        chk({tag, ".o"}, int'(rsp_o), o);
        chk({tag, ".id"}, int'(rsp_id), id);
    endtask

    task automatic set_req(input int k, input int a, input int b,
                           input int s);
        req_i0[k*W +: W] = W'(a);
        req_i1[k*W +: W] = W'(b);
        req_s[k*4 +: 4]  = 4'(s);
    endtask

    initial begin
        rst    = 1'b1;
        req_v  = '0;
        req_i0 = '0;
        req_i1 = '0;
        req_s  = '0;
        rsp_r  = 1'b1;
        tick();
        tick();
        chk_rsp("reset", 0, 0, 0);
        chk("reset.req_r", int'(req_r), 0);
        rst = 1'b0;

        // 1: single add
        set_req(0, 8'h05, 8'h03, 4'b0000);
        req_v = 4'b0001;
        #1;
        chk("t1.req_r", int'(req_r), 4'b0001);
        tick();
        chk_rsp("t1", 1, 8'h08, 0);
        req_v = '0;

        // 2: all requesting sub, round-robin from 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < N; k++) set_req(k, 8'h10, k, 4'b1000);
        req_v = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2.req_r", int'(req_r), 1 << (i % N));
            tick();
            chk_rsp("t2", 1, 8'h10 - (i % N), i % N);
        end
        req_v = '0;
        tick();
        chk_rsp("t2.drain", 0, 8'h10, 0);

        // 3: compares and wrap on requester 2
        set_req(2, 8'h80, 8'h01, 4'b0010);
        req_v = 4'b0100;
        #1;
        chk("t3.req_r", int'(req_r), 4'b0100);
        tick();
        chk_rsp("t3.slt", 1, 8'h01, 2);
        set_req(2, 8'h80, 8'h01, 4'b0011);
        tick();
        chk_rsp("t3.sltu", 1, 8'h00, 2);
        set_req(2, 8'hFF, 8'h02, 4'b0000);
        tick();
        chk_rsp("t3.wrap", 1, 8'h01, 2);
        req_v = '0;

        // 4: stall with a pending request from 1
        rsp_r = 1'b0;
        set_req(1, 8'h20, 8'h01, 4'b0000);
        req_v = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4.stall_req_r", int'(req_r), 0);
            tick();
            chk_rsp("t4.stall", 1, 8'h01, 2);
        end
        rsp_r = 1'b1;
        #1;
        chk("t4.req_r", int'(req_r), 4'b0010);
        tick();
        chk_rsp("t4.new", 1, 8'h21, 1);

        // 5: reset while busy, then first grant is 0
        for (int k = 0; k < N; k++) set_req(k, k, 1, 4'b0000);
        req_v = 4'b1111;
        rst   = 1'b1;
        tick();
        chk_rsp("t5.rst", 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("t5.req_r", int'(req_r), 4'b0001);
        tick();
        chk_rsp("t5.first", 1, 8'h01, 0);
        req_v = '0;
        tick();
        chk_rsp("t5.drain", 0, 8'h01, 0);

`ifdef IDVR_ADDSUB_ARB_ERR_EN
        // 6: illegal op then legal op
        set_req(2, 8'h33, 8'h11, 4'b0101);
        req_v = 4'b0100;
        tick();
        chk_rsp("t6.ill", 1, 8'h00, 2);
        chk("t6.err", int'(rsp_err), 1);
        set_req(2, 8'h03, 8'h04, 4'b0000);
        tick();
        chk_rsp("t6.legal", 1, 8'h07, 2);
        chk("t6.err_clr", int'(rsp_err), 0);
        req_v = '0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
